// File: rtl/spi_bus_pkg.sv
// Shared types and helpers for the SPI bus router: FSM state encoding and
// chip-select level mapping.
package spi_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StGap,
    StActive
  } state_e;

  // A byte boundary is reached when the low three count bits return to zero.
  localparam int unsigned ByteMask = 7;

  function automatic logic cs_level(input logic active, input logic pol_bit);
    return active ? pol_bit : ~pol_bit;
  endfunction

endpackage

// File: rtl/spi_gap_timer.sv
// Down-counter timing the break-before-make gap; load wins over decrement.
module spi_gap_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [Width-1:0] value_i,
  output logic [Width-1:0] count_o,
  output logic             expired_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (en_i) begin
      count_d = count_q - Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o   = count_q;
  assign expired_o = (count_q == '0);

endmodule

// File: rtl/spi_bus_router.sv
// SPI fabric between one master and NUM_CH slaves: code decode, break-before-make
// gap between selections, per-channel CS polarity / SCK idle level, MISO mux, bit counter.
module spi_bus_router
  import spi_bus_pkg::*;
#(
  parameter int unsigned       NUM_CH      = 4,
  parameter int unsigned       SEL_W       = 4,
  parameter int unsigned       GAP_CYC     = 4,
  parameter logic [NUM_CH-1:0] CS_ACT_HIGH = '1,
  parameter logic [NUM_CH-1:0] CPOL        = '0,
  parameter int unsigned       CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [SEL_W-1:0]  ss_code,
  input  logic              sck_in,
  input  logic              mosi_in,
  output logic              miso_out,
  output logic [NUM_CH-1:0] cs_out,
  output logic [NUM_CH-1:0] sck_out,
  output logic              mosi_out,
  input  logic [NUM_CH-1:0] miso_in,
  output logic [SEL_W-1:0]  active_ch,
  output logic              busy,
  output logic [CNT_W-1:0]  bit_cnt,
  output logic              byte_done
);

  localparam logic [SEL_W-1:0] NoCh = SEL_W'(NUM_CH);
  localparam int unsigned GapW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  code_q, tgt_q, tgt_d;
  logic              sck_q;
  logic [NUM_CH-1:0] cs_out_q, cs_out_d, sck_out_q, sck_out_d;
  logic              miso_q, miso_d, mosi_q;
  logic [SEL_W-1:0]  active_ch_q, active_ch_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d, cnt_next;
  logic              byte_done_q, byte_done_d;

  logic             code_valid, code_chg, rise;
  logic             gap_load, gap_expired;
  logic [GapW-1:0]  gap_count;
  logic             cnt_clr, cnt_inc, is_active, sel;

  spi_gap_timer #(
    .Width(GapW)
  ) u_gap_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (gap_load),
    .en_i     ((state_q == StGap) && (gap_count != '0)),
    .value_i  (GapW'(GAP_CYC - 1)),
    .count_o  (gap_count),
    .expired_o(gap_expired)
  );

  // The FSM works on the registered code so a change is judged against tgt_q.
  always_comb begin
    code_valid = (code_q < NoCh);
    code_chg   = (code_q != tgt_q);
    rise       = sck_in & ~sck_q;
    state_d    = state_q;
    tgt_d      = tgt_q;
    gap_load   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (code_valid) begin
          state_d  = StGap;
          tgt_d    = code_q;
          gap_load = 1'b1;
        end
      end
      StGap: begin
        if (!code_valid) begin
          state_d = StIdle;
          tgt_d   = NoCh;
        end else if (code_chg) begin
          tgt_d    = code_q;
          gap_load = 1'b1;
        end else if (gap_expired) begin
          state_d = StActive;
          cnt_clr = 1'b1;
        end
      end
      StActive: begin
        // A code change wins over a coincident SCK rise.
        if (code_chg) begin
          if (!code_valid) begin
            state_d = StIdle;
            tgt_d   = NoCh;
          end else begin
            state_d  = StGap;
            tgt_d    = code_q;
            gap_load = 1'b1;
          end
        end else begin
          cnt_inc = rise;
        end
      end
      default: begin
        state_d = StIdle;
        tgt_d   = NoCh;
      end
    endcase
  end

  always_comb begin
    cnt_next    = bit_cnt_q + CNT_W'(1);
    bit_cnt_d   = cnt_clr ? '0 : (cnt_inc ? cnt_next : bit_cnt_q);
    // A wrap lands on zero, so it also satisfies the byte-boundary test.
    byte_done_d = cnt_inc && ((cnt_next & CNT_W'(ByteMask)) == '0);
    is_active   = (state_d == StActive);
    active_ch_d = is_active ? tgt_d : NoCh;
    busy_d      = (state_d != StIdle);
    miso_d      = 1'b0;
    sel         = 1'b0;
    cs_out_d    = '0;
    sck_out_d   = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      sel          = is_active && (tgt_d == SEL_W'(i));
      cs_out_d[i]  = cs_level(sel, CS_ACT_HIGH[i]);
      sck_out_d[i] = sel ? sck_in : CPOL[i];
      if (sel) begin
        miso_d = miso_in[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      code_q      <= NoCh;
      tgt_q       <= NoCh;
      sck_q       <= 1'b0;
      cs_out_q    <= ~CS_ACT_HIGH;
      sck_out_q   <= CPOL;
      miso_q      <= 1'b0;
      mosi_q      <= 1'b0;
      active_ch_q <= NoCh;
      busy_q      <= 1'b0;
      bit_cnt_q   <= '0;
      byte_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      code_q      <= ss_code;
      tgt_q       <= tgt_d;
      sck_q       <= sck_in;
      cs_out_q    <= cs_out_d;
      sck_out_q   <= sck_out_d;
      miso_q      <= miso_d;
      mosi_q      <= mosi_in;
      active_ch_q <= active_ch_d;
      busy_q      <= busy_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign cs_out    = cs_out_q;
  assign sck_out   = sck_out_q;
  assign miso_out  = miso_q;
  assign mosi_out  = mosi_q;
  assign active_ch = active_ch_q;
  assign busy      = busy_q;
  assign bit_cnt   = bit_cnt_q;
  assign byte_done = byte_done_q;

endmodule

// File: tb/tb_spi_bus_router.sv
// Directed bench for spi_bus_router: a default instance plus one with mixed CS
// polarity and CPOL, both driven by the same master stimulus.
module tb_spi_bus_router;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] ss_code;
  logic       sck_in, mosi_in;
  logic [3:0] miso_in;

  logic        miso_out, mosi_out, busy, byte_done;
  logic [3:0]  cs_out, sck_out, active_ch;
  logic [15:0] bit_cnt;
  logic        miso_out2, mosi_out2, busy2, byte_done2;
  logic [3:0]  cs_out2, sck_out2, active_ch2;
  logic [15:0] bit_cnt2;

  int n_total = 0;
  int n_bad   = 0;
  int nbd;

  always #5 clk = ~clk;

  spi_bus_router dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_code  (ss_code),
    .sck_in   (sck_in),
    .mosi_in  (mosi_in),
    .miso_out (miso_out),
    .cs_out   (cs_out),
    .sck_out  (sck_out),
    .mosi_out (mosi_out),
    .miso_in  (miso_in),
    .active_ch(active_ch),
    .busy     (busy),
    .bit_cnt  (bit_cnt),
    .byte_done(byte_done)
  );

  spi_bus_router #(
    .CS_ACT_HIGH(4'b1110),
    .CPOL       (4'b0001)
  ) dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ss_code  (ss_code),
    .sck_in   (sck_in),
    .mosi_in  (mosi_in),
    .miso_out (miso_out2),
    .cs_out   (cs_out2),
    .sck_out  (sck_out2),
    .mosi_out (mosi_out2),
    .miso_in  (miso_in),
    .active_ch(active_ch2),
    .busy     (busy2),
    .bit_cnt  (bit_cnt2),
    .byte_done(byte_done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n   = 1'b0;
    ss_code = 4'd15;
    sck_in  = 1'b0;
    mosi_in = 1'b0;
    miso_in = 4'b0000;
    tick();
    tick();
    check_eq("rst_cs", cs_out, 4'b0000);
    check_eq("rst_sck", sck_out, 4'b0000);
    check_eq("rst_ach", active_ch, 4'd4);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_cnt", bit_cnt, 0);
    check_eq("rst_bd", byte_done, 0);
    check_eq("rst_miso", miso_out, 0);
    check_eq("rst_cs2", cs_out2, 4'b0001);
    check_eq("rst_sck2", sck_out2, 4'b0001);
    rst_n = 1'b1;
    tick();

    // 1: select channel 1 from idle
    ss_code = 4'd1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("t1_busy", busy, (i >= 2) ? 1 : 0);
      check_eq("t1_cs", cs_out, (i == 6) ? 4'b0010 : 4'b0000);
    end
    check_eq("t1_ach", active_ch, 4'd1);
    check_eq("t1_cnt", bit_cnt, 0);

    // 2: sixteen SCK rises on channel 1
    miso_in = 4'b0010;
    mosi_in = 1'b1;
    tick();
    check_eq("t2_miso", miso_out, 1);
    check_eq("t2_mosi", mosi_out, 1);
    check_eq("t2_mosi2", mosi_out2, 1);
    nbd = 0;
    for (int i = 1; i <= 16; i++) begin
      sck_in = 1'b1;
      tick();
      nbd += int'(byte_done);
      check_eq("t2_bd", byte_done, (i % 8 == 0) ? 1 : 0);
      check_eq("t2_sck_hi", sck_out, 4'b0010);
      check_eq("t2_cnt", bit_cnt, i);
      sck_in = 1'b0;
      tick();
      nbd += int'(byte_done);
      check_eq("t2_sck_lo", sck_out, 4'b0000);
    end
    check_eq("t2_nbd", nbd, 2);
    check_eq("t2_cnt16", bit_cnt, 16);

    // 3: switch 1 -> 2 through a full gap
    mosi_in = 1'b0;
    ss_code = 4'd2;
    tick();
    check_eq("t3_cs0", cs_out, 4'b0010);
    check_eq("t3_mosi", mosi_out, 0);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check_eq("t3_cs", cs_out, (i == 5) ? 4'b0100 : 4'b0000);
      if (i == 1) check_eq("t3_hold", bit_cnt, 16);
    end
    check_eq("t3_cnt0", bit_cnt, 0);
    check_eq("t3_ach", active_ch, 4'd2);

    // 6a: invalid code in ACTIVE with a coincident rise
    for (int i = 0; i < 3; i++) begin
      sck_in = 1'b1;
      tick();
      sck_in = 1'b0;
      tick();
    end
    check_eq("t6a_cnt3", bit_cnt, 3);
    miso_in = 4'b0100;
    tick();
    check_eq("t6a_miso1", miso_out, 1);
    ss_code = 4'd15;
    tick();
    check_eq("t6a_still", cs_out, 4'b0100);
    sck_in = 1'b1;
    tick();
    check_eq("t6a_busy", busy, 0);
    check_eq("t6a_cs", cs_out, 4'b0000);
    check_eq("t6a_miso", miso_out, 0);
    check_eq("t6a_ach", active_ch, 4'd4);
    check_eq("t6a_cnt", bit_cnt, 3);
    check_eq("t6a_sck", sck_out, 4'b0000);
    check_eq("t6a_bd", byte_done, 0);
    sck_in = 1'b0;
    tick();

    // 4: code change 2 -> 3 mid-gap restarts the gap
    ss_code = 4'd2;
    tick();
    tick();
    tick();
    check_eq("t4_busy", busy, 1);
    ss_code = 4'd3;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("t4_cs", cs_out, (i == 6) ? 4'b1000 : 4'b0000);
    end
    check_eq("t4_ach", active_ch, 4'd3);

    // 5: mixed polarity instance selects channel 0
    check_eq("t5_cs2_pre", cs_out2, 4'b1001);
    ss_code = 4'd0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      check_eq("t5_cs2", cs_out2, (i == 6) ? 4'b0000 : ((i == 1) ? 4'b1001 : 4'b0001));
      check_eq("t5_sck2", sck_out2, (i == 6) ? 4'b0000 : 4'b0001);
    end
    check_eq("t5_ach2", active_ch2, 4'd0);
    check_eq("t5_cs", cs_out, 4'b0001);
    sck_in = 1'b1;
    tick();
    check_eq("t5_sck2_hi", sck_out2, 4'b0001);
    sck_in = 1'b0;
    tick();
    check_eq("t5_sck2_lo", sck_out2, 4'b0000);
    miso_in = 4'b0001;
    check_eq("t5_lag", miso_out2, 0);
    tick();
    check_eq("t5_miso2_1", miso_out2, 1);
    miso_in = 4'b0000;
    tick();
    check_eq("t5_miso2_0", miso_out2, 0);

    // 6b: asynchronous reset mid-transfer
    sck_in = 1'b1;
    tick();
    check_eq("t6b_bd2", byte_done2, 0);
    sck_in = 1'b0;
    tick();
    check_eq("t6b_cnt2", bit_cnt2, 2);
    miso_in = 4'b0001;
    tick();
    check_eq("t6b_miso2", miso_out2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6b_busy2", busy2, 0);
    check_eq("t6b_cs2", cs_out2, 4'b0001);
    check_eq("t6b_sck2", sck_out2, 4'b0001);
    check_eq("t6b_cnt2z", bit_cnt2, 0);
    check_eq("t6b_miso2z", miso_out2, 0);
    check_eq("t6b_ach2", active_ch2, 4'd4);
    check_eq("t6b_cs", cs_out, 4'b0000);
    check_eq("t6b_cnt", bit_cnt, 0);
    rst_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
